// File: rtl/mem_fill_responder_if.sv
// Bus bundle for the block-fill responder: fill request, write-through
// port and the response stream. The requester is the master.
interface mem_fill_responder_if;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic [15:0] resp_addr;
    logic        resp_last;
    logic        busy;

    modport master (
        output req_valid, req_addr, wr_en, wr_addr, wr_data,
        input  req_ready, wr_ready, resp_valid, resp_data, resp_addr,
               resp_last, busy
    );

    modport slave (
        input  req_valid, req_addr, wr_en, wr_addr, wr_data,
        output req_ready, wr_ready, resp_valid, resp_data, resp_addr,
               resp_last, busy
    );
endinterface

// File: rtl/mem_fill_responder.sv
// Block-fill responder: a word array that answers an aligned block fill
// after a fixed latency, streaming BLOCK_WORDS words in ascending order,
// and accepts single-word write-through while idle.
module mem_fill_responder #(
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 8,
    parameter int DEPTH_LOG2  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_fill_responder_if.slave  bus
);

    // word_idx runs 0..BLOCK_WORDS: the extra value is the drain cycle in
    // which the final word sits in the output register.
    localparam int               CNT_W     = $clog2(BLOCK_WORDS) + 1;
    localparam int               DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0]       WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [15:0]      BASE_MASK = ~16'((BLOCK_WORDS * 2) - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] DRAIN_IDX = CNT_W'(BLOCK_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              wait_cnt;
    logic [CNT_W-1:0]        word_idx;
    logic [15:0]             base;
    logic                    idle;
    logic                    rd_en;
    logic                    fill_accept;
    logic                    wr_accept;
    logic [15:0]             rd_addr;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [DEPTH_LOG2-1:0]   wr_idx;
    logic [15:0]             mem [DEPTH];
    logic [15:0]             rd_q;
    logic                    resp_valid_q;
    logic                    resp_last_q;
    logic [15:0]             resp_addr_q;
    logic                    unused_bits;

    // Handshakes: both ports are only open while idle.
    assign fill_accept = bus.req_valid && idle;
    assign wr_accept   = bus.wr_en && idle;

    // Blocks are aligned, so the block offset never carries past 16 bits.
    assign rd_addr = base + (16'(word_idx) << 1);
    assign rd_idx  = rd_addr[DEPTH_LOG2:1];
    assign wr_idx  = bus.wr_addr[DEPTH_LOG2:1];

    // Byte-select bit and (for small arrays) aliased upper bits are dropped.
    assign unused_bits = ^{rd_addr, bus.wr_addr};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept, fixed wait, then stream plus one drain cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (fill_accept) begin
                    next_state = (LATENCY > 1) ? ST_WAIT : ST_BURST;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                if (word_idx == DRAIN_IDX) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode: ready only when idle, array read issued per burst word.
    always_comb begin
        idle  = (state == ST_IDLE);
        rd_en = (state == ST_BURST) && (word_idx < DRAIN_IDX);
    end

    // Latency down-counter, burst word counter and latched block base.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
            word_idx <= '0;
            base     <= 16'h0000;
        end else if (fill_accept) begin
            wait_cnt <= WAIT_INIT;
            word_idx <= '0;
            base     <= bus.req_addr & BASE_MASK;
        end else begin
            if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ST_BURST) begin
                word_idx <= (word_idx == DRAIN_IDX) ? '0 : word_idx + 1'b1;
            end
        end
    end

    // Word array: writes only happen while idle and reads only during a
    // burst, so a same-edge write is visible to the fill it accompanies.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_idx] <= bus.wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_idx];
        end
    end

    // Response qualifiers registered alongside the synchronous array read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_addr_q  <= 16'h0000;
        end else begin
            resp_valid_q <= rd_en;
            resp_last_q  <= rd_en && (word_idx == LAST_IDX);
            resp_addr_q  <= rd_en ? rd_addr : 16'h0000;
        end
    end

    assign bus.req_ready  = idle;
    assign bus.wr_ready   = idle;
    assign bus.busy       = !idle;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_last  = resp_last_q;
    assign bus.resp_addr  = resp_addr_q;
    // The array output register is not reset; gating keeps data at zero
    // whenever no word is being presented, including through reset.
    assign bus.resp_data  = resp_valid_q ? rd_q : 16'h0000;

endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: a LATENCY=4 and a LATENCY=1 instance,
// checked against a word-array reference model.
module tb_mem_fill_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_fill_responder_if bus4();
    mem_fill_responder_if bus1();

    mem_fill_responder #(.LATENCY(4), .BLOCK_WORDS(8), .DEPTH_LOG2(15)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    mem_fill_responder #(.LATENCY(1), .BLOCK_WORDS(8), .DEPTH_LOG2(15)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Stimulus goes to the selected instance; the other sees idle inputs.
    int          sel = 0;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = 16'h0;
    logic [15:0] wr_data = 16'h0;

    assign bus4.req_valid = (sel == 0) && req_valid;
    assign bus4.req_addr  = req_addr;
    assign bus4.wr_en     = (sel == 0) && wr_en;
    assign bus4.wr_addr   = wr_addr;
    assign bus4.wr_data   = wr_data;
    assign bus1.req_valid = (sel == 1) && req_valid;
    assign bus1.req_addr  = req_addr;
    assign bus1.wr_en     = (sel == 1) && wr_en;
    assign bus1.wr_addr   = wr_addr;
    assign bus1.wr_data   = wr_data;

    logic        cur_req_ready, cur_wr_ready, cur_resp_valid, cur_resp_last, cur_busy;
    logic [15:0] cur_resp_data, cur_resp_addr;

    always_comb begin
        if (sel == 1) begin
            cur_req_ready  = bus1.req_ready;
            cur_wr_ready   = bus1.wr_ready;
            cur_resp_valid = bus1.resp_valid;
            cur_resp_last  = bus1.resp_last;
            cur_busy       = bus1.busy;
            cur_resp_data  = bus1.resp_data;
            cur_resp_addr  = bus1.resp_addr;
        end else begin
            cur_req_ready  = bus4.req_ready;
            cur_wr_ready   = bus4.wr_ready;
            cur_resp_valid = bus4.resp_valid;
            cur_resp_last  = bus4.resp_last;
            cur_busy       = bus4.busy;
            cur_resp_data  = bus4.resp_data;
            cur_resp_addr  = bus4.resp_addr;
        end
    end

    // Reference model: one 16-bit word per even byte address, per instance.
    logic [15:0] model [2][32768];
    logic [15:0] seen_data [8];
    logic [15:0] seen_addr [8];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        checks++;
        if (cur_wr_ready !== 1'b1) begin
            fails++;
            $display("FAIL wr_ready_idle: got %b expected 1", cur_wr_ready);
        end else passes++;
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model[sel][a / 2] = d;
    endtask

    task automatic write_block(input logic [15:0] b);
        for (int i = 0; i < 8; i++) begin
            do_write(b + 16'(2 * i), 16'($urandom));
        end
    endtask

    // Issue a fill and check latency, every word and the return to idle.
    task automatic do_fill(input logic [15:0] addr, input bit wr_during);
        int          lat;
        int          k;
        logic [15:0] exp_base;
        logic [15:0] ea;
        lat = (sel == 1) ? 1 : 4;
        exp_base = addr - (addr % 16);
        checks++;
        if (cur_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL req_ready_before_fill: got %b expected 1", cur_req_ready);
        end else passes++;
        req_valid = 1'b1;
        req_addr = addr;
        tick();
        req_valid = 1'b0;
        wr_en = 1'b0;
        req_addr = 16'($urandom);
        k = 0;
        while (cur_resp_valid !== 1'b1 && k < 20) begin
            checks++;
            if (cur_busy !== 1'b1 || cur_resp_data !== 16'h0 || cur_resp_addr !== 16'h0
                || cur_resp_last !== 1'b0 || cur_req_ready !== 1'b0) begin
                fails++;
                $display("FAIL wait_outputs: busy=%b data=%h addr=%h last=%b rdy=%b expected 1/0/0/0/0",
                         cur_busy, cur_resp_data, cur_resp_addr, cur_resp_last, cur_req_ready);
            end else passes++;
            tick();
            k++;
        end
        checks++;
        if (k != lat) begin
            fails++;
            $display("FAIL fill_latency: got %0d expected %0d", k, lat);
        end else passes++;
        if (cur_resp_valid !== 1'b1) return;
        for (int i = 0; i < 8; i++) begin
            ea = exp_base + 16'(2 * i);
            seen_data[i] = cur_resp_data;
            seen_addr[i] = cur_resp_addr;
            checks++;
            if (cur_resp_valid !== 1'b1 || cur_busy !== 1'b1) begin
                fails++;
                $display("FAIL burst_valid[%0d]: valid=%b busy=%b expected 1/1", i, cur_resp_valid, cur_busy);
            end else passes++;
            checks++;
            if (cur_resp_addr !== ea) begin
                fails++;
                $display("FAIL burst_addr[%0d]: got %h expected %h", i, cur_resp_addr, ea);
            end else passes++;
            checks++;
            if (cur_resp_data !== model[sel][ea / 2]) begin
                fails++;
                $display("FAIL burst_data[%0d]: got %h expected %h", i, cur_resp_data, model[sel][ea / 2]);
            end else passes++;
            checks++;
            if (cur_resp_last !== (i == 7)) begin
                fails++;
                $display("FAIL burst_last[%0d]: got %b expected %b", i, cur_resp_last, (i == 7));
            end else passes++;
            if (wr_during) begin
                checks++;
                if (cur_wr_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL wr_ready_busy: got %b expected 0", cur_wr_ready);
                end else passes++;
                wr_en = 1'b1;
                wr_addr = 16'h1002;
                wr_data = 16'h5555;
            end
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (cur_resp_valid !== 1'b0 || cur_req_ready !== 1'b1 || cur_busy !== 1'b0) begin
            fails++;
            $display("FAIL after_burst: valid=%b req_ready=%b busy=%b expected 0/1/0",
                     cur_resp_valid, cur_req_ready, cur_busy);
        end else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++;
            if (cur_resp_valid !== 1'b0 || cur_busy !== 1'b0 || cur_resp_data !== 16'h0
                || cur_resp_addr !== 16'h0 || cur_resp_last !== 1'b0) begin
                fails++;
                $display("FAIL in_reset[%0d]: valid=%b busy=%b data=%h addr=%h last=%b expected zeros",
                         s, cur_resp_valid, cur_busy, cur_resp_data, cur_resp_addr, cur_resp_last);
            end else passes++;
        end
        sel = 0;
        rst = 1'b1;
        tick();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++;
            if (cur_req_ready !== 1'b1 || cur_wr_ready !== 1'b1 || cur_busy !== 1'b0
                || cur_resp_valid !== 1'b0) begin
                fails++;
                $display("FAIL after_reset[%0d]: req_ready=%b wr_ready=%b busy=%b valid=%b expected 1/1/0/0",
                         s, cur_req_ready, cur_wr_ready, cur_busy, cur_resp_valid);
            end else passes++;
        end
        sel = 0;
        tick();
    endtask

    task automatic test_write_then_fill();
        for (int i = 0; i < 8; i++) begin
            do_write(16'h1000 + 16'(2 * i), 16'hA000 + 16'(i));
        end
        do_fill(16'h1006, 1'b0);
        checks++;
        if (seen_data[7] !== 16'hA007 || seen_addr[7] !== 16'h100E) begin
            fails++;
            $display("FAIL wtf_last_word: got %h@%h expected a007@100e", seen_data[7], seen_addr[7]);
        end else passes++;
    endtask

    task automatic test_same_edge();
        write_block(16'h2000);
        wr_en = 1'b1;
        wr_addr = 16'h2004;
        wr_data = 16'hBEEF;
        model[0][16'h2004 / 2] = 16'hBEEF;
        do_fill(16'h2000, 1'b0);
        checks++;
        if (seen_data[2] !== 16'hBEEF) begin
            fails++;
            $display("FAIL same_edge_word2: got %h expected beef", seen_data[2]);
        end else passes++;
    endtask

    task automatic test_write_while_busy();
        do_fill(16'h1000, 1'b1);
        do_fill(16'h1000, 1'b0);
        checks++;
        if (seen_data[1] !== 16'hA001 || seen_addr[1] !== 16'h1002) begin
            fails++;
            $display("FAIL busy_write_ignored: got %h@%h expected a001@1002", seen_data[1], seen_addr[1]);
        end else passes++;
    endtask

    task automatic test_top_of_space();
        write_block(16'hFFF0);
        do_fill(16'hFFFA, 1'b0);
        checks++;
        if (seen_addr[0] !== 16'hFFF0 || seen_addr[7] !== 16'hFFFE) begin
            fails++;
            $display("FAIL top_of_space: first %h last %h expected fff0/fffe", seen_addr[0], seen_addr[7]);
        end else passes++;
    endtask

    task automatic test_reset_mid_burst();
        int k;
        req_valid = 1'b1;
        req_addr = 16'h1000;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (cur_resp_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (cur_resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_burst_start: got valid %b expected 1", cur_resp_valid);
        end else passes++;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (cur_resp_valid !== 1'b0 || cur_busy !== 1'b0 || cur_resp_data !== 16'h0
            || cur_resp_addr !== 16'h0) begin
            fails++;
            $display("FAIL reset_abort: valid=%b busy=%b data=%h addr=%h expected 0/0/0/0",
                     cur_resp_valid, cur_busy, cur_resp_data, cur_resp_addr);
        end else passes++;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (cur_req_ready !== 1'b1 || cur_resp_valid !== 1'b0 || cur_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: req_ready=%b valid=%b busy=%b expected 1/0/0",
                     cur_req_ready, cur_resp_valid, cur_busy);
        end else passes++;
        do_fill(16'h1000, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] b;
        for (int n = 0; n < 6; n++) begin
            sel = n % 2;
            #1;
            b = 16'($urandom) & 16'hFFF0;
            write_block(b);
            do_write(16'($urandom), 16'($urandom));
            do_fill(b | 16'($urandom_range(0, 15)), 1'b0);
        end
        sel = 0;
        #1;
    endtask

    task automatic test_min_latency();
        sel = 1;
        #1;
        write_block(16'h4000);
        write_block(16'h4010);
        do_fill(16'h4005, 1'b0);
        do_fill(16'h401E, 1'b0);
        sel = 0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_then_fill();
        test_same_edge();
        test_write_while_busy();
        test_top_of_space();
        test_reset_mid_burst();
        test_random();
        test_min_latency();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_fill_responder.md
MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- LATENCY, 4: cycles from request-accept edge to first response word; legal range 1..15.
- BLOCK_WORDS, 8: 16-bit words per block fill; power of two, 2..16.
- DEPTH_LOG2, 15: log2 of the internal word array depth.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: block-fill request.
- req_addr, in, 16: byte address anywhere inside the requested block.
- req_ready, out, 1: responder can accept a fill.
- wr_en, in, 1: single-word write-through request.
- wr_addr, in, 16: write byte address; bit 0 ignored.
- wr_data, in, 16: write data.
- wr_ready, out, 1: write can be accepted.
- resp_valid, out, 1: resp_data and resp_addr are valid this cycle.
- resp_data, out, 16: returned word.
- resp_addr, out, 16: byte address of the returned word.
- resp_last, out, 1: final word of the block.
- busy, out, 1: fill in progress (not IDLE).

Function
REQ-003 Three-state FSM: IDLE, WAIT, BURST.
REQ-004 req_ready and wr_ready are 1 only in IDLE.
REQ-005 Word index is addr[DEPTH_LOG2:1]; address bits above DEPTH_LOG2 are ignored (aliasing).
REQ-006 Fill accept: req_valid & req_ready at a rising edge.
- Block base = req_addr with low log2(BLOCK_WORDS)+1 bits cleared, latched on accept.
- req_addr is don't-care after accept.
REQ-007 After accept: FSM → WAIT if LATENCY>1, else directly → BURST.
REQ-008 WAIT lasts exactly LATENCY-1 cycles, counted by an internal down-counter, then → BURST.
REQ-009 First resp_valid=1 occurs in the cycle that begins LATENCY edges after the accept edge.
REQ-010 BURST emits BLOCK_WORDS words, one per cycle, in ascending address order from the block base (no critical-word-first).
- resp_valid held 1 for all BLOCK_WORDS cycles, no gaps.
- No back-pressure input exists; the requester must sink every word.
REQ-011 resp_addr = base + 2*i for word i; resp_last=1 only for i = BLOCK_WORDS-1.
REQ-012 After the last word: FSM → IDLE; req_ready=1 in the next cycle.
REQ-013 Block at the top of the space (e.g. base 0xFFF0) returns 0xFFF0..0xFFFE; the address never carries out of 16 bits.
REQ-014 Write accept: wr_en & wr_ready at a rising edge commits wr_data to the array at that edge (single cycle, no response).
REQ-015 wr_en while wr_ready=0 is ignored; no write is performed and nothing is queued.
REQ-016 Same-edge write and fill accept: both are accepted; the write commits first, so the fill returns the new data for that word.
REQ-017 While resp_valid=0: resp_data, resp_addr and resp_last are 0.
REQ-018 The array is read synchronously; the registered output is aligned with resp_valid.
REQ-019 busy=1 in WAIT and BURST.

Reset
REQ-020 rst=0 asynchronously forces the FSM to IDLE and clears counters and the latched base.
- Forces resp_valid=0, resp_last=0, resp_data=0, resp_addr=0, busy=0.
- req_ready and wr_ready go to 1 with reset deasserted.
REQ-021 Reset mid-WAIT or mid-BURST aborts the fill; no further words are emitted, and the first cycle after release is IDLE.
REQ-022 Array contents are not affected by reset and are undefined until written.

Verification
REQ-023 Write-then-fill: write 0x1000..0x100E with 0xA000+i, then fill req_addr=0x1006.
- Required: first resp_valid 4 cycles after accept.
- 8 consecutive words 0xA000..0xA007 at 0x1000..0x100E.
- resp_last on the 8th word.
- req_ready=1 in the next cycle.
REQ-024 Same-edge write/fill: wr_addr=0x2004, wr_data=0xBEEF, with fill req_addr=0x2000 on the same edge. Required: word 2 returns 0xBEEF.
REQ-025 Write while busy: wr_en=1 with wr_addr=0x1002 during BURST. Required: ignored; a later fill of 0x1000 still returns 0xA001 at 0x1002.
REQ-026 Top of space: fill req_addr=0xFFFA. Required: addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
REQ-027 Reset mid-burst: rst low after word 3.
- Required: resp_valid=0 immediately, busy=0.
- After release, a new fill restarts at word 0 with full LATENCY.
REQ-028 Minimum latency: LATENCY=1. Required: resp_valid on the cycle after accept; back-to-back fills have exactly one IDLE cycle between bursts.
